// File: rtl/audio_app.sv
// Four-channel programmable audio delay with a 6-bit serial programming port.
// Optional `AUDIO_APP_ERR_STICKY_EN: err_ stays low from its first error until reset.
module audio_app #(
    parameter int DATA_W = 16,
    parameter int DLY_W  = 3
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] di_0,
    input  logic [DATA_W-1:0] di_1,
    input  logic [DATA_W-1:0] di_2,
    input  logic [DATA_W-1:0] di_3,
    output logic [DATA_W-1:0] do_0,
    output logic [DATA_W-1:0] do_1,
    output logic [DATA_W-1:0] do_2,
    output logic [DATA_W-1:0] do_3,
    input  logic              prgrm_in,
    input  logic              prgrm_go_,
    output logic              err_
);
    localparam int NCH     = 4;
    localparam int DEPTH   = 2 ** DLY_W;
    localparam int FRAME_W = 3 + DLY_W;
    localparam int CNT_W   = $clog2(FRAME_W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    logic [DATA_W-1:0]     w_di [NCH];
    logic [NCH*DATA_W-1:0] w_do_flat;
    logic [DLY_W-1:0]      r_dly [NCH];

    assign w_di[0] = di_0;
    assign w_di[1] = di_1;
    assign w_di[2] = di_2;
    assign w_di[3] = di_3;
    assign do_0 = w_do_flat[0*DATA_W +: DATA_W];
    assign do_1 = w_do_flat[1*DATA_W +: DATA_W];
    assign do_2 = w_do_flat[2*DATA_W +: DATA_W];
    assign do_3 = w_do_flat[3*DATA_W +: DATA_W];

    genvar gi, gj;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DATA_W-1:0] r_line [DEPTH-1];
            logic [DATA_W-1:0] w_taps [DEPTH];
            logic [DATA_W-1:0] r_do;

            // Tap 0 is the live input, so D=0 still costs one register stage.
            assign w_taps[0] = w_di[gi];
            for (gj = 1; gj < DEPTH; gj++) begin : g_tap
                assign w_taps[gj] = r_line[gj-1];
            end

            always_ff @(posedge clk or posedge rst_) begin
                if (rst_) begin
                    for (int k = 0; k < DEPTH-1; k++) r_line[k] <= '0;
                    r_do <= '0;
                end else begin
                    r_line[0] <= w_di[gi];
                    for (int k = 1; k < DEPTH-1; k++) r_line[k] <= r_line[k-1];
                    r_do <= w_taps[r_dly[gi]];
                end
            end

            assign w_do_flat[gi*DATA_W +: DATA_W] = r_do;
        end
    endgenerate

    state_t            r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [DLY_W:0]    r_frame;   // bits 1..FRAME_W-2, oldest at LSB
    logic              r_err_n;
    logic              w_commit, w_err_set, w_err_clr;
    logic [1:0]        w_ch;
    logic [DLY_W-1:0]  w_d;

    assign w_ch = r_frame[1:0];
    assign w_d  = {prgrm_in, r_frame[DLY_W:2]};
    assign err_ = r_err_n;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;
        w_err_set    = 1'b0;
        w_err_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!prgrm_go_) begin
                    if (prgrm_in) begin
                        w_err_set    = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_err_clr    = 1'b1;
                        w_cnt_next   = CNT_W'(1);
                        w_state_next = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (prgrm_go_) begin
                    w_err_set    = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == CNT_W'(FRAME_W-1)) begin
                    w_commit     = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (prgrm_go_) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_frame <= '0;
            r_err_n <= 1'b1;
            for (int k = 0; k < NCH; k++) r_dly[k] <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (r_state == S_SHIFT && !prgrm_go_) r_frame <= {prgrm_in, r_frame[DLY_W:1]};
            if (w_commit) r_dly[w_ch] <= w_d;
            if (w_err_set) r_err_n <= 1'b0;
`ifndef AUDIO_APP_ERR_STICKY_EN
            else if (w_err_clr) r_err_n <= 1'b1;
`endif
        end
    end

`ifdef AUDIO_APP_ERR_STICKY_EN
    logic w_unused_clr;
    assign w_unused_clr = w_err_clr;
`endif
endmodule

// File: tb/tb_audio_app.sv
// Self-checking bench for audio_app: frame table, hand sequences and random traffic
// against a history-queue model of the delay lines.
module tb_audio_app;
`ifdef AUDIO_APP_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic [15:0] di_v [4];
    logic [15:0] dout [4];
    logic        prgrm_in = 1'b0;
    logic        prgrm_go_ = 1'b1;
    logic        err_;

    always #5 clk = ~clk;

    audio_app dut (
        .clk(clk), .rst_(rst_),
        .di_0(di_v[0]), .di_1(di_v[1]), .di_2(di_v[2]), .di_3(di_v[3]),
        .do_0(dout[0]), .do_1(dout[1]), .do_2(dout[2]), .do_3(dout[3]),
        .prgrm_in(prgrm_in), .prgrm_go_(prgrm_go_), .err_(err_)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          di_mode = 0;       // 0 random, 1 incrementing, 2 hold
    int          m_dly [4];
    logic        m_err;
    logic [15:0] hist [4][$];

    typedef struct {
        logic [5:0] bits;
        int         nlow;
        logic       exp_err_ns;
        logic       exp_err_st;
    } frame_vec_t;

    function automatic logic [5:0] mk(input logic rw, input logic [1:0] ch, input logic [2:0] d);
        return {d, ch, rw};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            hist[c].delete();
            for (int k = 0; k < 8; k++) hist[c].push_back(16'h0000);
            m_dly[c] = 0;
        end
        m_err = 1'b1;
    endtask

    task automatic drive_di();
        for (int c = 0; c < 4; c++) begin
            case (di_mode)
                0: di_v[c] = 16'($urandom);
                1: di_v[c] = di_v[c] + 16'(c + 1);
                default: ;
            endcase
        end
    endtask

    // One clock: model the edge, compare all outputs, then present the next samples.
    task automatic tick();
        logic [15:0] exp_do;
        @(posedge clk);
        #1;
        if (rst_) model_reset();
        else begin
            for (int c = 0; c < 4; c++) begin
                hist[c].push_front(di_v[c]);
                void'(hist[c].pop_back());
            end
        end
        for (int c = 0; c < 4; c++) begin
            exp_do = rst_ ? 16'h0000 : hist[c][m_dly[c]];
            check($sformatf("do_%0d", c), 32'(dout[c]), 32'(exp_do));
        end
        check("err_", 32'(err_), 32'(m_err));
        drive_di();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            prgrm_go_ = 1'b1;
            prgrm_in  = 1'($urandom);
            tick();
        end
    endtask

    // Drives prgrm_go_ low for nlow cycles, then high for one; expectations follow the frame rules.
    task automatic send_frame(input logic [5:0] bits, input int nlow);
        for (int i = 0; i < nlow; i++) begin
            prgrm_go_ = 1'b0;
            prgrm_in  = (i < 6) ? bits[i] : 1'($urandom);
            if (i == 0) begin
                if (bits[0]) m_err = 1'b0;
                else if (!STICKY) m_err = 1'b1;
            end
            tick();
            if (i == 5 && !bits[0]) m_dly[bits[2:1]] = int'(bits[5:3]);
        end
        prgrm_go_ = 1'b1;
        prgrm_in  = 1'($urandom);
        if (nlow < 6 && !bits[0]) m_err = 1'b0;
        tick();
        $display("frame rw=%0d ch=%0d d=%0d low=%0d -> err_=%0d", bits[0], bits[2:1], bits[5:3], nlow, err_);
    endtask

    frame_vec_t vecs [11];

    initial begin
        vecs[0]  = '{mk(0, 0, 3), 6, 1'b1, 1'b1};
        vecs[1]  = '{mk(1, 1, 5), 6, 1'b0, 1'b0};
        vecs[2]  = '{mk(0, 1, 2), 7, 1'b1, 1'b0};
        vecs[3]  = '{mk(0, 3, 4), 3, 1'b0, 1'b0};
        vecs[4]  = '{mk(0, 3, 6), 6, 1'b1, 1'b0};
        vecs[5]  = '{mk(1, 2, 1), 2, 1'b0, 1'b0};
        vecs[6]  = '{mk(1, 0, 7), 6, 1'b0, 1'b0};
        vecs[7]  = '{mk(0, 2, 0), 8, 1'b1, 1'b0};
        vecs[8]  = '{mk(0, 1, 7), 5, 1'b0, 1'b0};
        vecs[9]  = '{mk(0, 0, 2), 1, 1'b0, 1'b0};
        vecs[10] = '{mk(0, 0, 7), 6, 1'b1, 1'b0};

        for (int c = 0; c < 4; c++) di_v[c] = 16'h0000;
        model_reset();
        tick();
        tick();
        rst_ = 1'b0;
        idle(3);

        // Frame table: random samples flow while each frame is applied.
        di_mode = 0;
        for (int v = 0; v < 11; v++) begin
            send_frame(vecs[v].bits, vecs[v].nlow);
            check($sformatf("table_err_%0d", v), 32'(err_),
                  32'(STICKY ? vecs[v].exp_err_st : vecs[v].exp_err_ns));
            idle(2);
        end
        idle(10);

        // Reset with all channels at D=7 and constant inputs.
        di_mode = 2;
        di_v[0] = 16'h0011; di_v[1] = 16'h0022; di_v[2] = 16'h0044; di_v[3] = 16'h0088;
        for (int c = 0; c < 4; c++) send_frame(mk(0, 2'(c), 3'd7), 6);
        idle(10);
        #2;
        rst_ = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) check($sformatf("async_rst_do_%0d", c), 32'(dout[c]), 32'h0);
        check("async_rst_err", 32'(err_), 32'h1);
        tick();
        tick();
        rst_ = 1'b0;
        idle(4);
        check("post_rst_do_3", 32'(dout[3]), 32'h0088);

        // Delay accuracy on ch2 with a counting input.
        di_mode = 1;
        for (int c = 0; c < 4; c++) di_v[c] = 16'(16'h0100 * (c + 1));
        send_frame(6'b101100, 6);
        idle(12);

        // Live delay change on ch1: 7 then 1, history must carry over.
        send_frame(mk(0, 1, 7), 6);
        idle(10);
        send_frame(mk(0, 1, 1), 6);
        idle(6);

        // Error then recovery by a valid write.
        send_frame(mk(0, 3, 2), 3);
        check("abort_err", 32'(err_), 32'h0);
        idle(2);
        send_frame(mk(0, 3, 5), 6);
        check("recover_err", 32'(err_), STICKY ? 32'h0 : 32'h1);
        idle(4);

        // Random traffic.
        di_mode = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0)
                send_frame(6'($urandom), int'($urandom_range(1, 8)));
            else
                idle(int'($urandom_range(1, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
